// File: rtl/lsu_mem.sv
// lsu_mem: load/store unit between execute and write-back. Drives a req/ack data bus,
// steers store lanes, extends load data and reports misaligned/illegal/timeout faults.
module lsu_mem #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  operation,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] data_rs2,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        exc,
  output logic [1:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  // state | meaning
  // IDLE  | waiting for valid_in; decodes and classifies on accept
  // REQ   | bus request outstanding; waits for mem_ack or timeout
  // DONE  | one-cycle wb_valid/exc pulse; core advances on this edge
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_timer;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  assign w_is_load  = (operation == OP_LOAD);
  assign w_is_store = (operation == OP_STORE);
  assign stall      = valid_in & (r_state != DONE);

  always_comb begin
    w_illegal = 1'b0;
    if (w_is_load)
      w_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else if (w_is_store)
      w_illegal = (funct3 > 3'b010);
  end

  // funct3[1:0] encodes access size for both signed and unsigned loads
  assign w_misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    if (w_is_store) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << alu_result[1:0];
          w_wdata = {4{data_rs2[7:0]}};
        end
        2'b01: begin
          w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{data_rs2[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = data_rs2;
        end
      endcase
    end
  end

  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_f3)
      3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld = {24'd0, w_byte};
      3'b101:  w_ld = {16'd0, w_half};
      default: w_ld = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= 8'd0;
      r_off     <= 2'd0;
      r_f3      <= 3'd0;
      wb_valid  <= 1'b0;
      wb_data   <= 32'd0;
      exc       <= 1'b0;
      exc_code  <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_state <= DONE;
            if (!w_is_load && !w_is_store) begin
              wb_data  <= alu_result;
              wb_valid <= 1'b1;
            end else if (w_illegal) begin
              exc      <= 1'b1;
              exc_code <= 2'b11;
            end else if (w_misalign) begin
              exc      <= 1'b1;
              exc_code <= 2'b01;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= w_is_store;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
              r_off     <= alu_result[1:0];
              r_f3      <= funct3;
              r_timer   <= TMR_LOAD;
              r_state   <= REQ;
            end
          end
        end
        REQ: begin
          // an ack arriving on the last permitted cycle still completes the access
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= mem_we ? 32'd0 : w_ld;
            r_state  <= DONE;
          end else if (r_timer == 8'd0) begin
            mem_req  <= 1'b0;
            exc      <= 1'b1;
            exc_code <= 2'b10;
            r_state  <= DONE;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        DONE: begin
          wb_valid <= 1'b0;
          exc      <= 1'b0;
          exc_code <= 2'b00;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: randomized scoreboard bench for lsu_mem; a reference model queues expected
// write-back/exception and bus transactions, independent monitors pop and compare them.
module tb_lsu_mem;
  localparam int TO = 4;

  logic        clk, rst, valid_in;
  logic [6:0]  operation;
  logic [2:0]  funct3;
  logic [31:0] alu_result, data_rs2;
  logic        stall, wb_valid, exc, mem_req, mem_we, mem_ack;
  logic [31:0] wb_data, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  exc_code;
  logic [3:0]  mem_be;

  lsu_mem #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .operation(operation), .funct3(funct3),
    .alu_result(alu_result), .data_rs2(data_rs2), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .exc(exc), .exc_code(exc_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct { bit is_exc; logic [1:0] code; logic [31:0] data; } out_t;
  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int cycles; } bus_t;

  out_t out_q[$];
  bus_t bus_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int          ack_at    = 0;
  logic [31:0] rd_val    = 0;
  bit          force_ack = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: queues expected results, returns expected stall cycle count.
  function automatic int model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] rs2, input logic [31:0] rd, input int ack);
    out_t   o;
    bus_t   b;
    int     sz, off;
    longint mask;
    logic [31:0] v;
    bit ld, st;
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    o.is_exc = 0; o.code = 0; o.data = 0;
    if (!ld && !st) begin
      o.data = a;
      out_q.push_back(o);
      return 1;
    end
    if ((ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2)) begin
      o.is_exc = 1; o.code = 2'b11;
      out_q.push_back(o);
      return 1;
    end
    sz  = 1 << f3[1:0];
    off = int'(a % 4);
    if ((a % sz) != 0) begin
      o.is_exc = 1; o.code = 2'b01;
      out_q.push_back(o);
      return 1;
    end
    b.we   = st;
    b.addr = a - off;
    b.be   = ld ? 4'hF : 4'(((1 << sz) - 1) << off);
    if (sz == 1)      b.wdata = rs2[7:0] * 32'h01010101;
    else if (sz == 2) b.wdata = rs2[15:0] * 32'h00010001;
    else              b.wdata = rs2;
    b.cycles = (ack == 0) ? TO : ack;
    bus_q.push_back(b);
    if (ack == 0) begin
      o.is_exc = 1; o.code = 2'b10;
    end else if (ld) begin
      mask = (64'd1 << (8 * sz)) - 1;
      v = (rd >> (8 * off)) & mask[31:0];
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask[31:0];
      o.data = v;
    end
    out_q.push_back(o);
    return 1 + b.cycles;
  endfunction

  // Memory responder: acks on the ack_at-th cycle of a request (0 = never).
  initial begin
    int rcyc;
    rcyc = 0; mem_ack = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req) rcyc++; else rcyc = 0;
      mem_ack   = force_ack || (mem_req && rcyc == ack_at);
      mem_rdata = mem_ack ? rd_val : $urandom;
    end
  end

  // Write-back / exception monitor
  initial begin
    out_t o;
    forever begin
      @(negedge clk);
      if (wb_valid || exc) begin
        check("wb_and_exc_exclusive", {31'd0, wb_valid & exc}, 32'd0);
        if (out_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: got wb_valid=%b exc=%b expected no pulse", wb_valid, exc);
        end else begin
          o = out_q.pop_front();
          check("exc", {31'd0, exc}, {31'd0, o.is_exc});
          check("exc_code", {30'd0, exc_code}, {30'd0, o.code});
          if (!o.is_exc) check("wb_data", wb_data, o.data);
        end
      end
    end
  end

  // Bus monitor
  initial begin
    bus_t b;
    bit   prev;
    int   cnt;
    prev = 0; cnt = 0;
    b = '{we: 0, addr: 0, be: 0, wdata: 0, cycles: 0};
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        cnt = 1;
        if (bus_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_req: got mem_req=1 addr %h expected no request", mem_addr);
        end else begin
          b = bus_q.pop_front();
          check("mem_addr", mem_addr, b.addr);
          check("mem_we", {31'd0, mem_we}, {31'd0, b.we});
          check("mem_be", {28'd0, mem_be}, {28'd0, b.be});
          if (b.we) check("mem_wdata", mem_wdata, b.wdata);
        end
      end else if (mem_req) begin
        cnt++;
        check("mem_addr_held", mem_addr, b.addr);
      end else if (prev) begin
        check("req_cycles", cnt, b.cycles);
      end
      prev = mem_req;
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [31:0] rd, input int ack);
    int exp_n, n;
    exp_n = model(op, f3, a, rs2, rd, ack);
    ack_at = ack; rd_val = rd;
    valid_in = 1; operation = op; funct3 = f3; alu_result = a; data_rs2 = rs2;
    n = 1;
    @(posedge clk); #1;
    while (stall && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_cycles", n, exp_n);
    @(posedge clk); #1;
    valid_in = 0;
    operation = 7'($urandom); alu_result = $urandom;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int r;
    rst = 1; valid_in = 0; operation = 0; funct3 = 0; alu_result = 0; data_rs2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_exc", {31'd0, exc}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_stall_idle", {31'd0, stall}, 32'd0);
    valid_in = 1; #1;
    check("rst_stall_follows_valid", {31'd0, stall}, 32'd1);
    valid_in = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    issue(7'b0100011, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    issue(7'b0000011, 3'b000, 32'h203, 32'h0, 32'h80FF0000, 1);
    issue(7'b0000011, 3'b100, 32'h203, 32'h0, 32'h80FF0000, 1);
    issue(7'b0000011, 3'b101, 32'h202, 32'h0, 32'h80FF0000, 1);
    issue(7'b0100011, 3'b001, 32'h101, 32'h1234, 32'h0, 1);
    issue(7'b0000011, 3'b011, 32'h100, 32'h0, 32'h0, 1);
    issue(7'b0110011, 3'b000, 32'h1234, 32'h0, 32'h0, 1);
    issue(7'b0000011, 3'b010, 32'h400, 32'h0, 32'h0, 0);
    issue(7'b0100011, 3'b000, 32'h507, 32'h000000A5, 32'h0, TO);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      op = 7'b0000011;
      else if (r < 8) op = 7'b0100011;
      else begin
        op = 7'($urandom);
        if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0110011;
      end
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (op == 7'b0100011) f3 = 3'($urandom_range(0, 2));
        else if (f3 == 3 || f3 >= 6) f3 = 3'b010;
      end
      issue(op, f3, $urandom, $urandom, $urandom, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO));
    end

    // Reset in the middle of an access, then a stray ack
    bus_q.push_back('{we: 0, addr: 32'h300, be: 4'hF, wdata: 32'h0, cycles: 2});
    ack_at = 3; rd_val = 32'h12345678;
    valid_in = 1; operation = 7'b0000011; funct3 = 3'b010; alu_result = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req_active", {31'd0, mem_req}, 32'd1);
    rst = 1; valid_in = 0;
    @(posedge clk); #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("midrst_exc", {31'd0, exc}, 32'd0);
    check("midrst_exc_code", {30'd0, exc_code}, 32'd0);
    check("midrst_wb_data", wb_data, 32'd0);
    rst = 0; force_ack = 1;
    repeat (2) begin @(posedge clk); #1; end
    force_ack = 0;
    check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    repeat (4) begin @(posedge clk); #1; end

    check("out_queue_drained", out_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
